// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch port, load/store port and memory bus seen by unified_mem_arbiter.
// The master modport is the arbiter's view; slave is the pipeline/memory side.
interface unified_mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_valid;
    logic                  stall_if;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_valid;
    logic                  stall_mem;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  mem_ready;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_valid, stall_if, d_rdata, d_valid, stall_mem,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_valid, stall_if, d_rdata, d_valid, stall_mem,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported memory between the fetch and load/store ports, one transaction at a
// time; data wins ties unless fetch has been passed over STARVE_LIMIT times.
module unified_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic                   clk,
    input logic                   reset,
    unified_mem_arbiter_if.master bus
);
    localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyD} state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       starve_q, starve_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_valid_q, if_valid_d;
    logic                  d_valid_q, d_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    logic if_elig, d_elig, starve_full;

    // A request still high during its own completion cycle is stale and must not re-grant.
    assign if_elig     = bus.if_req & ~if_valid_q;
    assign d_elig      = bus.d_req & ~d_valid_q;
    assign starve_full = (starve_q == CntW'(STARVE_LIMIT));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        d_valid_d   = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (d_elig && !(if_elig && starve_full)) begin
                    state_d     = StBusyD;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                    if (if_elig && !starve_full) begin
                        starve_d = starve_q + CntW'(1);
                    end
                end else if (if_elig) begin
                    state_d    = StBusyIf;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = bus.if_addr;
                    starve_d   = '0;
                end
            end
            StBusyIf: begin
                if (bus.mem_ready) begin
                    state_d    = StIdle;
                    mem_req_d  = 1'b0;
                    if_rdata_d = bus.mem_rdata;
                    if_valid_d = 1'b1;
                end
            end
            StBusyD: begin
                if (bus.mem_ready) begin
                    state_d   = StIdle;
                    mem_req_d = 1'b0;
                    d_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        d_rdata_d = bus.mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            starve_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            d_valid_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            d_valid_q   <= d_valid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_valid  = if_valid_q;
    assign bus.stall_if  = bus.if_req & ~if_valid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.stall_mem = bus.d_req & ~d_valid_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed and random stimulus for unified_mem_arbiter, checked every cycle against a
// transaction-level model of the arbiter and a sparse memory array.
module tb_unified_mem_arbiter;
    localparam int unsigned Limit = 4;

    logic clk;
    logic reset;

    unified_mem_arbiter_if bus ();

    unified_mem_arbiter #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .STARVE_LIMIT(Limit)
    ) u_dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] mem_arr [logic [31:0]];

    // Model: owner 0 = bus idle, 1 = fetch in flight, 2 = data in flight.
    int          e_owner;
    int          e_starve;
    logic        e_we;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
    logic        e_if_valid, e_d_valid;
    logic        prev_req;
    logic [31:0] glog [$];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("mem_req", 32'(bus.mem_req), 32'(e_owner != 0));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wdata);
        chk("if_valid", 32'(bus.if_valid), 32'(e_if_valid));
        chk("d_valid", 32'(bus.d_valid), 32'(e_d_valid));
        chk("if_rdata", bus.if_rdata, e_if_rdata);
        chk("d_rdata", bus.d_rdata, e_d_rdata);
        chk("one_valid", 32'(bus.if_valid & bus.d_valid), 32'd0);
        if (bus.mem_req && !prev_req) glog.push_back(bus.mem_addr);
        prev_req = bus.mem_req;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic rdy);
        bus.if_req    = ir;
        bus.if_addr   = ia;
        bus.d_req     = dr;
        bus.d_we      = dw;
        bus.d_addr    = da;
        bus.d_wdata   = dwd;
        bus.mem_ready = rdy;
        bus.mem_rdata = (e_owner != 0) ? mem_rd(e_addr) : $urandom();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        reset      = 1'b0;
        e_owner    = 0;
        e_starve   = 0;
        e_we       = 1'b0;
        e_addr     = '0;
        e_wdata    = '0;
        e_if_rdata = '0;
        e_d_rdata  = '0;
        e_if_valid = 1'b0;
        e_d_valid  = 1'b0;
        prev_req   = 1'b0;
        check_outputs();
    endtask

    // One clock: apply inputs, check the stall outputs, advance the model, check the edge result.
    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                         input logic [31:0] da, input logic [31:0] dwd, input logic rdy);
        logic if_e, d_e, n_iv, n_dv;
        drive(ir, ia, dr, dw, da, dwd, rdy);
        #1;
        chk("stall_if", 32'(bus.stall_if), 32'(ir & ~e_if_valid));
        chk("stall_mem", 32'(bus.stall_mem), 32'(dr & ~e_d_valid));
        n_iv = 1'b0;
        n_dv = 1'b0;
        if (e_owner != 0) begin
            if (rdy) begin
                if (e_owner == 1) begin
                    n_iv       = 1'b1;
                    e_if_rdata = mem_rd(e_addr);
                end else begin
                    n_dv = 1'b1;
                    if (e_we) mem_arr[e_addr] = e_wdata;
                    else e_d_rdata = mem_rd(e_addr);
                end
                e_owner = 0;
            end
        end else begin
            if_e = ir & ~e_if_valid;
            d_e  = dr & ~e_d_valid;
            if (d_e && !(if_e && e_starve == int'(Limit))) begin
                e_owner = 2;
                e_we    = dw;
                e_addr  = da;
                e_wdata = dwd;
                if (if_e && e_starve < int'(Limit)) e_starve++;
            end else if (if_e) begin
                e_owner  = 1;
                e_we     = 1'b0;
                e_addr   = ia;
                e_starve = 0;
            end
        end
        e_if_valid = n_iv;
        e_d_valid  = n_dv;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    initial begin
        logic [31:0] gexp [7];
        logic        f_req, q_req, q_we;
        logic [31:0] f_addr, q_addr, q_wdata;

        reset = 1'b1;
        e_owner = 0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        do_reset();

        // Single fetch, zero wait states.
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        cycle(1'b1, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        cycle(1'b0, 32'h40, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Simultaneous fetch and load: data first.
        mem_arr[32'h2000] = 32'hDEAD_BEEF;
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'd0, 1'b0);
        cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'd0, 1'b1);
        chk("t2_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h2000, 32'd0, 1'b0);
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        cycle(1'b0, 32'h100, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Store with three wait states, then read it back.
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'h1234_5678, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'h10, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h10, 32'd0, 1'b1);
        chk("t3_readback", bus.d_rdata, 32'h1234_5678);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Starvation: four data grants with fetch pending, then fetch is forced.
        glog.delete();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'h500, 1'b1, 1'b0, 32'h3000, 32'd0, 1'b1);
            cycle(1'b0, 32'h500, 1'b1, 1'b0, 32'h3000, 32'd0, 1'b1);
            cycle(1'b0, 32'h500, 1'b0, 1'b0, 32'h3000, 32'd0, 1'b0);
        end
        cycle(1'b1, 32'h500, 1'b1, 1'b0, 32'h3000, 32'd0, 1'b0);
        cycle(1'b1, 32'h500, 1'b1, 1'b0, 32'h3000, 32'd0, 1'b1);
        cycle(1'b0, 32'h500, 1'b1, 1'b0, 32'h3000, 32'd0, 1'b0);
        cycle(1'b0, 32'h500, 1'b1, 1'b0, 32'h3000, 32'd0, 1'b1);
        cycle(1'b0, 32'h500, 1'b0, 1'b0, 32'h3000, 32'd0, 1'b0);
        // Counter cleared by the fetch grant, so data wins the next tie.
        cycle(1'b1, 32'h500, 1'b1, 1'b0, 32'h3000, 32'd0, 1'b0);
        cycle(1'b0, 32'h500, 1'b1, 1'b0, 32'h3000, 32'd0, 1'b1);
        cycle(1'b0, 32'h500, 1'b0, 1'b0, 32'h3000, 32'd0, 1'b0);
        gexp = '{32'h3000, 32'h3000, 32'h3000, 32'h3000, 32'h500, 32'h3000, 32'h3000};
        chk("starve_grants", 32'(glog.size()), 32'd7);
        for (int i = 0; i < 7; i++) chk("starve_order", glog[i], gexp[i]);

        // Reset in BUSY_D aborts the load.
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h2000, 32'd0, 1'b0);
        cycle(1'b0, 32'd0, 1'b1, 1'b0, 32'h2000, 32'd0, 1'b0);
        do_reset();
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'h2000, 32'd0, 1'b1);
        cycle(1'b0, 32'd0, 1'b0, 1'b0, 32'h2000, 32'd0, 1'b1);

        // Fetch request held through its valid cycle.
        cycle(1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        cycle(1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        cycle(1'b1, 32'h80, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        chk("t6_no_regrant", 32'(bus.mem_req), 32'd0);
        cycle(1'b1, 32'h84, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, 32'h84, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
        cycle(1'b0, 32'h84, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);

        // Random traffic from two well-behaved requesters and a random-latency memory.
        f_req = 1'b0; f_addr = '0;
        q_req = 1'b0; q_we = 1'b0; q_addr = '0; q_wdata = '0;
        for (int c = 0; c < 3000; c++) begin
            if (f_req && e_if_valid) f_req = ($urandom % 4 == 0);
            else if (!f_req) begin
                if ($urandom % 3 == 0) begin
                    f_req  = 1'b1;
                    f_addr = 32'($urandom_range(0, 63)) << 2;
                end
            end else if ($urandom % 32 == 0) f_req = 1'b0;
            if (q_req && e_d_valid) q_req = ($urandom % 4 == 0);
            else if (!q_req) begin
                if ($urandom % 3 == 0) begin
                    q_req   = 1'b1;
                    q_we    = 1'($urandom % 2);
                    q_addr  = 32'h1000 + (32'($urandom_range(0, 15)) << 2);
                    q_wdata = $urandom();
                end
            end else if ($urandom % 32 == 0) q_req = 1'b0;
            cycle(f_req, f_addr, q_req, q_we, q_addr, q_wdata, 1'($urandom % 3 != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates a single-ported unified instruction/data memory between the pipeline's fetch port (IF stage) and its load/store port (MEM stage). It sequences one memory transaction at a time over a ready-handshaked memory bus, returns read data to the winning requester, and drives per-port stall signals. The pipeline uses those stall signals to hold PC/IF_ID and freeze MEM/WB while a port waits. Data accesses have priority, and a bounded-starvation counter guarantees fetch progress.

## Interface
- ADDR_WIDTH, 32, byte address width on all ports
- DATA_WIDTH, 32, data width on all ports
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced (≥1)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_WIDTH  fetch address
- if_rdata  out  DATA_WIDTH  fetched word; valid when if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- stall_if  out  1  if_req & ~if_valid (combinational)
- d_req  in  1  load/store request; held with d_we/d_addr/d_wdata stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_WIDTH  data address
- d_wdata  in  DATA_WIDTH  store data
- d_rdata  out  DATA_WIDTH  load data; valid when d_valid and the access was a load
- d_valid  out  1  one-cycle completion pulse for data access
- stall_mem  out  1  d_req & ~d_valid (combinational)
- mem_req  out  1  memory transaction request (registered)
- mem_we  out  1  write enable to memory (registered)
- mem_addr  out  ADDR_WIDTH  memory address (registered)
- mem_wdata  out  DATA_WIDTH  memory write data (registered)
- mem_rdata  in  DATA_WIDTH  memory read data; sampled when mem_ready
- mem_ready  in  1  memory completes the current transaction this cycle

## Operation
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE arbitration, evaluated each cycle. An eligible request is one whose port is not asserting valid this cycle; a req still high during its own valid cycle is ignored.
  - Only d eligible: grant data.
  - Only if eligible: grant fetch.
  - Both eligible: grant data unless starve_cnt == STARVE_LIMIT, then grant fetch.
- On grant: latch address/we/wdata into the mem_* registers, set mem_req=1, and go to BUSY_D or BUSY_IF. A fetch grant always drives mem_we=0.
- BUSY_x: hold mem_* stable until mem_ready=1. On that edge:
  - deassert mem_req;
  - register mem_rdata into if_rdata (BUSY_IF) or d_rdata (BUSY_D load);
  - pulse x_valid for the next cycle;
  - return to IDLE.
- Stores leave d_rdata unchanged.
- starve_cnt, width $clog2(STARVE_LIMIT+1):
  - +1 on each data grant made while if_req is eligible;
  - clears on any fetch grant;
  - saturates at STARVE_LIMIT.
- Outputs hold their value outside the cases above. if_rdata and d_rdata persist until overwritten.

## Timing
- Reset: state=IDLE, starve_cnt=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0.
- Request sampled in IDLE at edge t → mem_req=1 from t+1.
- mem_ready sampled high at edge t+k (k≥1) → valid pulse and rdata available during cycle t+k+1; state is IDLE in that cycle.
- Minimum latency req→valid is 2 cycles, for memory with 0 wait states (mem_ready high the first cycle mem_req is high).
- Next grant can occur at the edge ending the valid cycle, so there is one idle bus cycle between back-to-back transactions.
- mem_ready while mem_req=0 is ignored.
- Requester dropping req mid-transaction: the transaction still completes and valid still pulses. The requester must tolerate this.
- Reset asserted in BUSY_x: the transaction is aborted, and no valid pulses for it. The memory shares the same reset.
- if_valid and d_valid are never high in the same cycle.

## Test plan
- Single fetch, mem_ready on first mem_req cycle:
  - if_req at edge 0 with if_addr=0x40 → mem_req=1, mem_addr=0x40, mem_we=0 in cycle 1;
  - if_valid=1 with if_rdata=mem value in cycle 2;
  - stall_if=1 in cycles 0–1.
- Simultaneous if_req (0x100) and d_req load (0x2000), memory returns 0xDEADBEEF → data granted first with d_valid and d_rdata=0xDEADBEEF, then fetch of 0x100 completes; stall_if is held throughout.
- Store d_addr=0x10, d_wdata=0x12345678, memory with 3 wait states → mem_we=1 and mem_addr/mem_wdata stable for 4 cycles; d_valid pulses once; d_rdata unchanged.
- Starvation, STARVE_LIMIT=4: if_req held while d_req is re-asserted after every completion → exactly 4 data grants, then a fetch grant, then data resumes; starve_cnt returns to 0.
- Reset asserted during BUSY_D with mem_ready low → next cycle all outputs are at reset values, and no d_valid pulse follows.
- Requester keeps req high through its valid cycle → no duplicate grant in that cycle; a new grant occurs only if req is still high the following cycle.
